// File: rtl/serial_alu_sequencer_if.sv
// serial_alu_sequencer_if: request/response bundle between two requesters and the sequencer
//   req_valid/req_ready : per-requester handshake, bit i = requester i
//   req_op/req_a/req_b  : packed per-requester opcode and operands
//   resp_*              : valid/ready response carrying id, result and timeout error
interface serial_alu_sequencer_if #(
  parameter int W    = 8,
  parameter int OP_W = 3
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*OP_W-1:0] req_op;
  logic [2*W-1:0]    req_a;
  logic [2*W-1:0]    req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [W-1:0]      resp_result;
  logic              resp_error;
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_error
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_error
  );
endinterface

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer: round-robin front end that frames requests to a bit-serial ALU
//   clk_i          : system clock, rising edge
//   rst_ni         : asynchronous active-low reset
//   bus            : request/response interface (slave side)
//   alu_reset_o    : active-high ALU reset, pulsed 2 cycles after a timeout
//   alu_data_in_o  : serial frame to the ALU (start, op, A, B; LSB-first)
//   alu_data_out_i : serial result from the ALU (start bit, then W bits LSB-first)
module serial_alu_sequencer #(
  parameter int W       = 8,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  serial_alu_sequencer_if.slave bus,
  output logic                  alu_reset_o,
  output logic                  alu_data_in_o,
  input  logic                  alu_data_out_i
);
  localparam int FL = 1 + OP_W + 2 * W;
  localparam logic [7:0] FL_M1 = 8'(FL - 1);
  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);
  localparam logic [7:0] W_M1  = 8'(W - 1);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, FLUSH, RESP} state_t;
  state_t        state_q, state_d;
  logic [FL-1:0] frame_q, frame_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;
  logic          rr_q, rr_d, id_q, id_d, err_q, err_d, gnt_id;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rr_q    <= 1'b1;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    cnt_d         = cnt_q;
    res_d         = res_q;
    rr_d          = rr_q;
    id_d          = id_q;
    err_d         = err_q;
    bus.req_ready = 2'b00;
    alu_reset_o   = 1'b0;
    alu_data_in_o = 1'b0;
    // rr_q holds the last winner; on contention the other requester wins
    gnt_id        = &bus.req_valid ? ~rr_q : bus.req_valid[1];
    case (state_q)
      IDLE: if (|bus.req_valid) begin
        bus.req_ready = gnt_id ? 2'b10 : 2'b01;
        rr_d          = gnt_id;
        id_d          = gnt_id;
        frame_d       = {gnt_id ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0],
                         gnt_id ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0],
                         gnt_id ? bus.req_op[2*OP_W-1:OP_W] : bus.req_op[OP_W-1:0],
                         1'b1};
        cnt_d         = '0;
        state_d       = SEND;
      end
      SEND: begin
        alu_data_in_o = frame_q[0];
        frame_d       = frame_q >> 1;
        cnt_d         = cnt_q == FL_M1 ? 8'd0 : cnt_q + 8'd1;
        state_d       = cnt_q == FL_M1 ? WAIT : SEND;
      end
      WAIT: begin
        cnt_d   = alu_data_out_i || cnt_q == TO_M1 ? 8'd0 : cnt_q + 8'd1;
        state_d = alu_data_out_i ? RECV : cnt_q == TO_M1 ? FLUSH : WAIT;
      end
      RECV: begin
        // shift in from the top so the first received bit ends up in res_q[0]
        res_d   = {alu_data_out_i, res_q[W-1:1]};
        err_d   = 1'b0;
        cnt_d   = cnt_q + 8'd1;
        state_d = cnt_q == W_M1 ? RESP : RECV;
      end
      FLUSH: begin
        alu_reset_o = 1'b1;
        res_d       = '0;
        err_d       = 1'b1;
        cnt_d       = cnt_q + 8'd1;
        state_d     = cnt_q == 8'd1 ? RESP : FLUSH;
      end
      RESP: state_d = bus.resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  assign bus.resp_valid  = state_q == RESP;
  assign bus.resp_id     = bus.resp_valid & id_q;
  assign bus.resp_error  = bus.resp_valid & err_q;
  assign bus.resp_result = bus.resp_valid ? res_q : '0;
endmodule
